// File: rtl/hazard_fwd_if.sv
// Bundles the pipeline-to-hazard-unit signals. The pipeline drives the master side and the
// hazard unit sits on the slave side.
interface hazard_fwd_if #(
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [REG_WIDTH-1:0] Rs1D;
  logic [REG_WIDTH-1:0] Rs2D;
  logic [REG_WIDTH-1:0] Rs1E;
  logic [REG_WIDTH-1:0] Rs2E;
  logic [REG_WIDTH-1:0] RdE;
  logic [REG_WIDTH-1:0] RdM;
  logic [REG_WIDTH-1:0] RdW;
  logic                 RegWriteE;
  logic                 RegWriteM;
  logic                 RegWriteW;
  logic                 LoadE;
  logic                 PCSrcE;
  logic                 clr_cnt;
  logic                 stallF;
  logic                 stallD;
  logic                 flushD;
  logic                 flushE;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, clr_cnt,
    input  stallF, stallD, flushD, flushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, clr_cnt,
    output stallF, stallD, flushD, flushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// RAW hazard, forwarding and redirect-flush control for the 5-stage rv32i pipeline, with
// saturating stall/flush event counters.
module hazard_fwd_unit #(
  parameter int unsigned REG_WIDTH = 5,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_fwd_if.slave hz
);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic                 hazE;
  logic                 hazM;
  logic                 stall;
  logic [CNT_WIDTH-1:0] stallCnt_q;
  logic [CNT_WIDTH-1:0] flushCnt_q;

  assign hazE = hz.RegWriteE && (hz.RdE != '0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign hazM = hz.RegWriteM && (hz.RdM != '0) && ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D));

  // Stall length emerges from the bubble moving down the pipe; nothing is counted down here.
  assign stall = FWD_EN ? (hz.LoadE && hazE) : (hazE || hazM);

  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b1;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (!rst) begin
      // A redirect squashes the dependent D instruction, so it overrides the stall.
      hz.flushD = hz.PCSrcE;
      hz.flushE = hz.PCSrcE || stall;
      hz.stallF = stall && !hz.PCSrcE;
      hz.stallD = stall && !hz.PCSrcE;
      if (FWD_EN) begin
        if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs1E)) begin
          hz.ForwardAE = 2'b10;
        end else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs1E)) begin
          hz.ForwardAE = 2'b01;
        end
        if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs2E)) begin
          hz.ForwardBE = 2'b10;
        end else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs2E)) begin
          hz.ForwardBE = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hz.clr_cnt) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (hz.stallD && (stallCnt_q != CntMax)) stallCnt_q <= stallCnt_q + CntOne;
      if (hz.PCSrcE && (flushCnt_q != CntMax)) flushCnt_q <= flushCnt_q + CntOne;
    end
  end

  assign hz.stall_cnt = stallCnt_q;
  assign hz.flush_cnt = flushCnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Drives a forwarding-mode unit (4-bit counters) and a stall-only unit (16-bit counters) with
// identical stimulus and checks both against a table, hand sequences and a reference model.
module tb_hazard_fwd_unit;
  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, loade, pcsrc;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] expF;
    logic [7:0] expS;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cntStallF = 0, cntFlushF = 0, cntStallS = 0, cntFlushS = 0;
  logic [7:0] gotF, gotS;
  vec_t tbl[12];

  hazard_fwd_if #(.REG_WIDTH(5), .CNT_WIDTH(4))  ifF ();
  hazard_fwd_if #(.REG_WIDTH(5), .CNT_WIDTH(16)) ifS ();

  hazard_fwd_unit #(.REG_WIDTH(5), .FWD_EN(1'b1), .CNT_WIDTH(4))  u_fwd (
    .clk(clk), .rst(rst), .hz(ifF)
  );
  hazard_fwd_unit #(.REG_WIDTH(5), .FWD_EN(1'b0), .CNT_WIDTH(16)) u_stl (
    .clk(clk), .rst(rst), .hz(ifS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic depends(input logic [4:0] a, input logic [4:0] b,
                                   input logic [4:0] rd, input logic we);
    return we && (rd != 0) && (rd == a || rd == b);
  endfunction

  // Youngest in-flight writer of src wins; x0 is never forwarded.
  function automatic logic [1:0] source(input logic [4:0] src, input in_t v);
    if (src == 0) return 2'b00;
    if (v.rwm && v.rdm == src) return 2'b10;
    if (v.rww && v.rdw == src) return 2'b01;
    return 2'b00;
  endfunction

  // Packed as {stallF, stallD, flushD, flushE, ForwardAE, ForwardBE}.
  function automatic logic [7:0] ref_out(input in_t v, input logic r, input bit fwd);
    logic s;
    logic [1:0] fa, fb;
    if (r) return 8'b0001_0000;
    if (fwd) s = v.loade && depends(v.rs1d, v.rs2d, v.rde, v.rwe);
    else s = depends(v.rs1d, v.rs2d, v.rde, v.rwe) || depends(v.rs1d, v.rs2d, v.rdm, v.rwm);
    fa = fwd ? source(v.rs1e, v) : 2'b00;
    fb = fwd ? source(v.rs2e, v) : 2'b00;
    if (v.pcsrc) return {4'b0011, fa, fb};
    return {s, s, 1'b0, s, fa, fb};
  endfunction

  function automatic int sat(input int x, input int maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  task automatic drive(input in_t v, input logic r, input logic c);
    rst = r;
    ifF.Rs1D = v.rs1d; ifF.Rs2D = v.rs2d; ifF.Rs1E = v.rs1e; ifF.Rs2E = v.rs2e;
    ifF.RdE = v.rde; ifF.RdM = v.rdm; ifF.RdW = v.rdw; ifF.RegWriteE = v.rwe;
    ifF.RegWriteM = v.rwm; ifF.RegWriteW = v.rww; ifF.LoadE = v.loade; ifF.PCSrcE = v.pcsrc;
    ifF.clr_cnt = c;
    ifS.Rs1D = v.rs1d; ifS.Rs2D = v.rs2d; ifS.Rs1E = v.rs1e; ifS.Rs2E = v.rs2e;
    ifS.RdE = v.rde; ifS.RdM = v.rdm; ifS.RdW = v.rdw; ifS.RegWriteE = v.rwe;
    ifS.RegWriteM = v.rwm; ifS.RegWriteW = v.rww; ifS.LoadE = v.loade; ifS.PCSrcE = v.pcsrc;
    ifS.clr_cnt = c;
  endtask

  // One pipeline cycle: outputs checked mid-cycle, counters checked just after the edge.
  task automatic step(input in_t v, input logic r, input logic c);
    logic [7:0] eF, eS;
    drive(v, r, c);
    @(negedge clk);
    eF = ref_out(v, r, 1'b1);
    eS = ref_out(v, r, 1'b0);
    gotF = {ifF.stallF, ifF.stallD, ifF.flushD, ifF.flushE, ifF.ForwardAE, ifF.ForwardBE};
    gotS = {ifS.stallF, ifS.stallD, ifS.flushD, ifS.flushE, ifS.ForwardAE, ifS.ForwardBE};
    chk("ctrl_fwd", int'(gotF), int'(eF));
    chk("ctrl_stl", int'(gotS), int'(eS));
    @(posedge clk);
    if (r || c) begin
      cntStallF = 0; cntFlushF = 0; cntStallS = 0; cntFlushS = 0;
    end else begin
      cntStallF = sat(cntStallF + int'(eF[6]), 15);
      cntStallS = sat(cntStallS + int'(eS[6]), 65535);
      cntFlushF = sat(cntFlushF + int'(v.pcsrc), 15);
      cntFlushS = sat(cntFlushS + int'(v.pcsrc), 65535);
    end
    #1;
    chk("stall_cnt_fwd", int'(ifF.stall_cnt), cntStallF);
    chk("flush_cnt_fwd", int'(ifF.flush_cnt), cntFlushF);
    chk("stall_cnt_stl", int'(ifS.stall_cnt), cntStallS);
    chk("flush_cnt_stl", int'(ifS.flush_cnt), cntFlushS);
  endtask

  function automatic in_t mk(input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                             input bit rwe, rwm, rww, ld, pc);
    in_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.loade = ld; v.pcsrc = pc;
    return v;
  endfunction

  initial begin
    in_t idle, lu, v;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0);

    tbl[0]  = '{mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0), 8'b0000_1000, 8'b0000_0000};
    tbl[1]  = '{mk(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0), 8'b0000_0100, 8'b0000_0000};
    tbl[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 8'b0000_0000, 8'b0000_0000};
    tbl[3]  = '{lu,                                      8'b1101_0000, 8'b1101_0000};
    tbl[4]  = '{mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0), 8'b0000_0000, 8'b1101_0000};
    tbl[5]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 8'b0000_0000, 8'b0000_0000};
    tbl[6]  = '{mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1), 8'b0011_0000, 8'b0011_0000};
    tbl[7]  = '{mk(3, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 8'b0000_0000, 8'b1101_0000};
    tbl[8]  = '{mk(3, 0, 3, 3, 0, 0, 3, 0, 0, 1, 0, 0), 8'b0000_0101, 8'b0000_0000};
    tbl[9]  = '{mk(0, 0, 9, 9, 0, 9, 9, 0, 1, 1, 0, 0), 8'b0000_1010, 8'b0000_0000};
    tbl[10] = '{mk(4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0), 8'b0000_0000, 8'b1101_0000};
    tbl[11] = '{mk(6, 0, 6, 0, 0, 6, 0, 0, 1, 0, 0, 0), 8'b0000_1000, 8'b1101_0000};

    // Reset with a live hazard: no stall, bubble into E, counters cleared.
    step(lu, 1'b1, 1'b0);
    chk("rst_ctrl_fwd", int'(gotF), 8'b0001_0000);
    chk("rst_ctrl_stl", int'(gotS), 8'b0001_0000);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].in, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_fwd", i), int'(gotF), int'(tbl[i].expF));
      chk($sformatf("tbl%0d_stl", i), int'(gotS), int'(tbl[i].expS));
    end

    // Producer of x7 advances E -> M -> W while the consumer waits in D.
    step(idle, 1'b0, 1'b1);
    step(lu, 1'b0, 1'b0);
    chk("seq_c1_stallD_fwd", int'(gotF[6]), 1);
    chk("seq_c1_stallD_stl", int'(gotS[6]), 1);
    step(mk(0, 7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0), 1'b0, 1'b0);
    chk("seq_c2_stallD_fwd", int'(gotF[6]), 0);
    chk("seq_c2_stallD_stl", int'(gotS[6]), 1);
    step(mk(0, 7, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0), 1'b0, 1'b0);
    chk("seq_c3_stallD_stl", int'(gotS[6]), 0);
    chk("seq_stall_cnt_fwd", int'(ifF.stall_cnt), 1);
    chk("seq_stall_cnt_stl", int'(ifS.stall_cnt), 2);

    // Redirect against a load-use hazard in the same cycle.
    step(idle, 1'b0, 1'b1);
    step(mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1), 1'b0, 1'b0);
    chk("redir_flush_cnt_fwd", int'(ifF.flush_cnt), 1);
    chk("redir_stall_cnt_fwd", int'(ifF.stall_cnt), 0);
    chk("redir_stall_cnt_stl", int'(ifS.stall_cnt), 0);

    // Saturation, clear-over-increment, then reset mid-stall.
    step(idle, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(lu, 1'b0, 1'b0);
    chk("sat_stall_cnt_fwd", int'(ifF.stall_cnt), 15);
    chk("sat_stall_cnt_stl", int'(ifS.stall_cnt), 20);
    step(lu, 1'b0, 1'b1);
    chk("clr_stall_cnt_fwd", int'(ifF.stall_cnt), 0);
    chk("clr_stall_cnt_stl", int'(ifS.stall_cnt), 0);
    step(lu, 1'b0, 1'b0);
    step(lu, 1'b1, 1'b0);
    chk("rst_mid_stallD_fwd", int'(gotF[6]), 0);
    chk("rst_mid_stallD_stl", int'(gotS[6]), 0);
    chk("rst_mid_cnt_stl", int'(ifS.stall_cnt), 0);

    for (int i = 0; i < 2000; i++) begin
      v.rs1d = 5'($urandom_range(0, 7)); v.rs2d = 5'($urandom_range(0, 7));
      v.rs1e = 5'($urandom_range(0, 7)); v.rs2e = 5'($urandom_range(0, 7));
      v.rde  = 5'($urandom_range(0, 7)); v.rdm  = 5'($urandom_range(0, 7));
      v.rdw  = 5'($urandom_range(0, 7));
      v.rwe = 1'($urandom); v.rwm = 1'($urandom); v.rww = 1'($urandom);
      v.loade = 1'($urandom); v.pcsrc = ($urandom_range(0, 7) == 0);
      step(v, ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
